conv556_sched: RTL and testbench



---
 rtl/conv556_sched_if.sv | 23 ++
 rtl/conv556_sched.sv | 105 ++++++++++
 tb/tb_conv556_sched.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/conv556_sched_if.sv
// conv556_sched_if: start/done, column-issue and output-pixel handshake of the conv556 sequencer.
// The perf counter ports exist only when CONV_SCHED_PERF_EN is defined.
interface conv556_sched_if #(parameter int CW = 5);
    logic start, busy, done, rd_en, conv_en, out_valid, out_ready;
    logic [CW-1:0] rd_row, rd_col, out_row, out_col;
`ifdef CONV_SCHED_PERF_EN
    logic [31:0] perf_busy_cycles, perf_stall_cycles;
`endif
    modport master (
        input  start, out_ready,
        output busy, done, rd_en, rd_row, rd_col, conv_en, out_valid, out_row, out_col
`ifdef CONV_SCHED_PERF_EN
        , output perf_busy_cycles, perf_stall_cycles
`endif
    );
    modport slave (
        output start, out_ready,
        input  busy, done, rd_en, rd_row, rd_col, conv_en, out_valid, out_row, out_col
`ifdef CONV_SCHED_PERF_EN
        , input perf_busy_cycles, perf_stall_cycles
`endif
    );
endinterface

// File: rtl/conv556_sched.sv
// conv556_sched: valid-mode 5x5x6 convolution sequencer with a latency-tracking tag pipe.
// Optional busy/stall cycle counters are built when CONV_SCHED_PERF_EN is defined.
module conv556_sched #(
    parameter int IN_W     = 14,
    parameter int IN_H     = 14,
    parameter int K        = 5,
    parameter int CONV_LAT = 2,
    parameter int CW       = 5
) (
    input logic clk,
    input logic rst,
    conv556_sched_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
    localparam logic [CONV_LAT-1:0] HEAD = ~(CONV_LAT'(1) << (CONV_LAT - 1));
    state_t st_q, st_d;
    logic [CW-1:0] r_q, r_d, c_q, c_d;
    logic [CONV_LAT-1:0] tv_q, tv_d;
    logic [CW-1:0] tr_q [CONV_LAT];
    logic [CW-1:0] tr_d [CONV_LAT];
    logic [CW-1:0] tc_q [CONV_LAT];
    logic [CW-1:0] tc_d [CONV_LAT];
    logic stall, issue, adv, row_end, last_issue;
    always_comb begin
        stall      = tv_q[CONV_LAT-1] & ~bus.out_ready;
        issue      = (st_q == RUN) & ~stall;
        adv        = ((st_q == RUN) | (st_q == DRAIN)) & ~stall;
        row_end    = c_q == CW'(IN_W - 1);
        last_issue = row_end && r_q == CW'(IN_H - K);
        st_d = st_q;
        r_d  = r_q;
        c_d  = c_q;
        tv_d = tv_q;
        tr_d = tr_q;
        tc_d = tc_q;
        if (st_q == IDLE && bus.start) begin
            st_d = RUN;
            r_d  = '0;
            c_d  = '0;
        end
        if (issue) begin
            c_d  = row_end ? '0 : c_q + 1'b1;
            r_d  = row_end ? r_q + 1'b1 : r_q;
            st_d = last_issue ? DRAIN : RUN;
        end
        if (adv) begin
            for (int i = CONV_LAT - 1; i > 0; i--) begin
                tv_d[i] = tv_q[i-1];
                tr_d[i] = tr_q[i-1];
                tc_d[i] = tc_q[i-1];
            end
            tv_d[0] = issue && c_q >= CW'(K - 1);
            tr_d[0] = r_q;
            tc_d[0] = c_q - CW'(K - 1);
        end
        if (st_q == DRAIN && (tv_q & HEAD) == '0 && !stall) st_d = FIN;
        if (st_q == FIN) st_d = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q <= IDLE;
            r_q  <= '0;
            c_q  <= '0;
            tv_q <= '0;
            tr_q <= '{default: '0};
            tc_q <= '{default: '0};
        end else begin
            st_q <= st_d;
            r_q  <= r_d;
            c_q  <= c_d;
            tv_q <= tv_d;
            tr_q <= tr_d;
            tc_q <= tc_d;
        end
    end
    // conv_en stays high through DRAIN: the datapath registers only capture on en,
    // so the final pixels must keep shifting toward convValue with the tags.
    assign bus.busy      = st_q != IDLE;
    assign bus.done      = st_q == FIN;
    assign bus.rd_en     = issue;
    assign bus.conv_en   = adv;
    assign bus.rd_row    = r_q;
    assign bus.rd_col    = c_q;
    assign bus.out_valid = tv_q[CONV_LAT-1];
    assign bus.out_row   = tr_q[CONV_LAT-1];
    assign bus.out_col   = tc_q[CONV_LAT-1];
`ifdef CONV_SCHED_PERF_EN
    logic [31:0] pb_q, pb_d, ps_q, ps_d;
    always_comb begin
        pb_d = (st_q == IDLE && bus.start) ? '0 : pb_q + 32'(st_q != IDLE);
        ps_d = (st_q == IDLE && bus.start) ? '0 : ps_q + 32'(stall);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pb_q <= '0;
            ps_q <= '0;
        end else begin
            pb_q <= pb_d;
            ps_q <= ps_d;
        end
    end
    assign bus.perf_busy_cycles  = pb_q;
    assign bus.perf_stall_cycles = ps_q;
`endif
endmodule

// File: tb/tb_conv556_sched.sv
// tb_conv556_sched: randomized-handshake bench for conv556_sched, default 14x14 map and a 5x5 / latency-1 map.
// Expected issues, pixels and timing come from raster-order arithmetic over the map geometry.
module tb_conv556_sched;
    localparam int CW = 5;
    localparam int K  = 5;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] start_m = '0;
    logic [1:0] rdy_m = '1;
    logic [1:0] busy_m, done_m, rd_m, ce_m, ov_m;
    logic [CW-1:0] rr_m [2];
    logic [CW-1:0] rc_m [2];
    logic [CW-1:0] or_m [2];
    logic [CW-1:0] oc_m [2];
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int t0 [2], ni [2], np [2], stl [2], acc [2], nd_last [2];
    bit act [2], vis [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    conv556_sched_if #(.CW(CW)) ba ();
    conv556_sched_if #(.CW(CW)) bb ();
    conv556_sched #(.IN_W(14), .IN_H(14), .K(K), .CONV_LAT(2), .CW(CW)) dut_a (.clk(clk), .rst(rst), .bus(ba));
    conv556_sched #(.IN_W(5), .IN_H(5), .K(K), .CONV_LAT(1), .CW(CW)) dut_b (.clk(clk), .rst(rst), .bus(bb));

    assign ba.start = start_m[0];
    assign bb.start = start_m[1];
    assign ba.out_ready = rdy_m[0];
    assign bb.out_ready = rdy_m[1];
    assign busy_m = {bb.busy, ba.busy};
    assign done_m = {bb.done, ba.done};
    assign rd_m   = {bb.rd_en, ba.rd_en};
    assign ce_m   = {bb.conv_en, ba.conv_en};
    assign ov_m   = {bb.out_valid, ba.out_valid};
    assign rr_m[0] = ba.rd_row;
    assign rr_m[1] = bb.rd_row;
    assign rc_m[0] = ba.rd_col;
    assign rc_m[1] = bb.rd_col;
    assign or_m[0] = ba.out_row;
    assign or_m[1] = bb.out_row;
    assign oc_m[0] = ba.out_col;
    assign oc_m[1] = bb.out_col;
`ifdef CONV_SCHED_PERF_EN
    logic [31:0] pb_m [2];
    logic [31:0] ps_m [2];
    assign pb_m[0] = ba.perf_busy_cycles;
    assign pb_m[1] = bb.perf_busy_cycles;
    assign ps_m[0] = ba.perf_stall_cycles;
    assign ps_m[1] = bb.perf_stall_cycles;
`endif

    function automatic int fw(int k);   return k ? 5 : 14; endfunction
    function automatic int fh(int k);   return k ? 5 : 14; endfunction
    function automatic int flat(int k); return k ? 1 : 2; endfunction
    function automatic int ow(int k);   return fw(k) - K + 1; endfunction
    function automatic int niss(int k); return (fh(k) - K + 1) * fw(k); endfunction
    function automatic int npix(int k); return (fh(k) - K + 1) * ow(k); endfunction

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Per-cycle reference: issue index ni and pixel index np map to raster coordinates;
    // each stall cycle pushes the whole schedule back by one cycle.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                string p;
                bit st, eb, ed;
                int nd;
                p  = k ? "b." : "a.";
                st = ov_m[k] & ~rdy_m[k];
                if (act[k] && st) stl[k]++;
                nd = t0[k] + niss(k) + flat(k) + 1 + stl[k];
                eb = act[k] && cyc > t0[k] && cyc <= nd;
                ed = eb && cyc == nd;
                chk({p, "busy"}, int'(busy_m[k]), int'(eb));
                chk({p, "done"}, int'(done_m[k]), int'(ed));
                chk({p, "rd_en"}, int'(rd_m[k]), int'(eb && ni[k] < niss(k) && !st));
                chk({p, "conv_en"}, int'(ce_m[k]), int'(eb && !ed && !st));
                if (!eb) chk({p, "ov_idle"}, int'(ov_m[k]), 0);
                if (rd_m[k]) begin
                    chk({p, "rd_row"}, int'(rr_m[k]), ni[k] / fw(k));
                    chk({p, "rd_col"}, int'(rc_m[k]), ni[k] % fw(k));
                    ni[k]++;
                end
                if (ov_m[k]) begin
                    chk({p, "out_row"}, int'(or_m[k]), np[k] / ow(k));
                    chk({p, "out_col"}, int'(oc_m[k]), np[k] % ow(k));
                    if (!vis[k]) chk({p, "pix_gap"}, cyc - acc[k], (np[k] % ow(k) == 0) ? K : 1);
                    vis[k] = 1'b1;
                    if (rdy_m[k]) begin
                        np[k]++;
                        acc[k] = cyc;
                        vis[k] = 1'b0;
                    end
                end
                if (ed) begin
                    chk({p, "n_issue"}, ni[k], niss(k));
                    chk({p, "n_pixel"}, np[k], npix(k));
                    act[k] = 1'b0;
                    nd_last[k] = nd;
                end
            end
        end
    end

    // mode 0: ready tied high; 1: random ready; 2: hold ready low for sn cycles once pixel (sr,sc) shows up
    task automatic run_pass(input int k, input int mode, input int sr, input int sc, input int sn,
                            input bit extra, input int rst_row);
        int n, hold;
        bit fired, was_rst;
        n = 0; hold = 0; fired = 1'b0; was_rst = 1'b0;
        @(posedge clk); #1;
        start_m[k] = 1'b1;
        rdy_m[k] = 1'b1;
        t0[k] = cyc; ni[k] = 0; np[k] = 0; stl[k] = 0;
        acc[k] = cyc + flat(k); vis[k] = 1'b0; act[k] = 1'b1;
        @(posedge clk); #1;
        start_m[k] = 1'b0;
        while (!done_m[k] && n < 3000) begin
            if (rst_row >= 0 && rd_m[k] && int'(rr_m[k]) == rst_row) begin
                rst = 1'b1;
                act[k] = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                was_rst = 1'b1;
                break;
            end
            if (mode == 1) rdy_m[k] = $urandom_range(0, 3) != 0;
            else if (mode == 2) begin
                if (!fired && ov_m[k] && int'(or_m[k]) == sr && int'(oc_m[k]) == sc) begin
                    hold = sn;
                    fired = 1'b1;
                end
                rdy_m[k] = hold == 0;
                if (hold > 0) hold--;
            end
            start_m[k] = extra && n == 30;
            @(posedge clk); #1;
            n++;
        end
        if (was_rst) begin
            repeat (4) @(posedge clk);
            #1;
            return;
        end
        chk("pass_done", int'(done_m[k]), 1);
        rdy_m[k] = 1'b1;
        start_m[k] = extra;
        @(posedge clk); #1;
        start_m[k] = 1'b0;
`ifdef CONV_SCHED_PERF_EN
        chk("perf_busy", int'(pb_m[k]), nd_last[k] - t0[k]);
        chk("perf_stall", int'(ps_m[k]), stl[k]);
`endif
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        act = '{1'b0, 1'b0};
        t0 = '{0, 0};
        stl = '{0, 0};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy_m[0]), 0);
        chk("rst_ov", int'(ov_m[0]), 0);
        chk("rst_rd", int'(rd_m[0]), 0);
        rst = 1'b0;
        run_pass(0, 0, 0, 0, 0, 1'b0, -1);
        run_pass(0, 2, 3, 2, 5, 1'b0, -1);
        run_pass(0, 0, 0, 0, 0, 1'b1, -1);
        run_pass(0, 0, 0, 0, 0, 1'b0, 4);
        run_pass(0, 0, 0, 0, 0, 1'b0, -1);
        run_pass(0, 1, 0, 0, 0, 1'b0, -1);
        run_pass(0, 1, 0, 0, 0, 1'b1, -1);
        run_pass(1, 0, 0, 0, 0, 1'b0, -1);
        run_pass(1, 2, 0, 0, 3, 1'b0, -1);
        run_pass(1, 1, 0, 0, 0, 1'b1, -1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
